// File: rtl/pe_sched_pkg.sv
// Shared types and per-tile word counts for the PE_Group scheduler.
// Stream index order everywhere: 0 = W, 1 = I, 2 = O (psum in).
package pe_sched_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int ADDR_WIDTH     = 10;
  localparam int TILE_CNT_WIDTH = 8;

  localparam int W_WORDS     = 4;
  localparam int I_WORDS     = 7;
  localparam int O_WORDS     = 4;
  localparam int NUM_STREAMS = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sched_state_e;

  function automatic int stream_words(input int s);
    case (s)
      0:       return W_WORDS;
      1:       return I_WORDS;
      default: return O_WORDS;
    endcase
  endfunction

endpackage

// File: rtl/pe_stream_reader.sv
// Streams num_tiles*Words contiguous buffer words into a valid/ready sink through a
// 2-entry skid buffer; read data is expected exactly one cycle after rd_en.
module pe_stream_reader #(
  parameter int DataWidth    = 32,
  parameter int AddrWidth    = 10,
  parameter int TileCntWidth = 8,
  parameter int Words        = 4
) (
  input  logic                    clk_i,
  input  logic                    aclr_ni,
  input  logic                    load_i,
  input  logic [TileCntWidth-1:0] num_tiles_i,
  input  logic [AddrWidth-1:0]    base_i,
  input  logic                    en_i,
  input  logic                    flush_i,
  output logic                    rd_en_o,
  output logic [AddrWidth-1:0]    rd_addr_o,
  input  logic [DataWidth-1:0]    rd_data_i,
  output logic                    valid_o,
  input  logic                    rdy_i,
  output logic [DataWidth-1:0]    data_o
);

  localparam int CntWidth = TileCntWidth + 4;

  logic [CntWidth-1:0]  total_q, total_d;
  logic [CntWidth-1:0]  issued_q, issued_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 inflight_q, inflight_d;
  logic [1:0]           occ_q, occ_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [DataWidth-1:0] buf_q [2];

  logic       push;
  logic       pop;
  logic [2:0] used;

  assign valid_o   = (occ_q != 2'd0);
  assign data_o    = buf_q[rd_ptr_q];
  assign pop       = valid_o && rdy_i;
  assign push      = inflight_q && !flush_i;
  assign rd_addr_o = addr_q;

  // Counting the word leaving this cycle as free lets back-to-back reads run at 1 word/cycle.
  assign used    = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
  assign rd_en_o = en_i && !flush_i && (issued_q < total_q) && (used < 3'd2);

  always_comb begin
    total_d    = total_q;
    issued_d   = issued_q;
    addr_d     = addr_q;
    inflight_d = rd_en_o;
    occ_d      = occ_q + 2'(push) - 2'(pop);
    wr_ptr_d   = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d   = pop ? ~rd_ptr_q : rd_ptr_q;
    if (rd_en_o) begin
      issued_d = issued_q + CntWidth'(1);
      addr_d   = addr_q + AddrWidth'(1);
    end
    if (flush_i || load_i) begin
      inflight_d = 1'b0;
      occ_d      = 2'd0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      issued_d   = '0;
    end
    if (load_i) begin
      total_d = CntWidth'(num_tiles_i) * CntWidth'(Words);
      addr_d  = base_i;
    end
  end

  always_ff @(posedge clk_i or negedge aclr_ni) begin
    if (!aclr_ni) begin
      total_q    <= '0;
      issued_q   <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      total_q    <= total_d;
      issued_q   <= issued_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      if (push) begin
        buf_q[wr_ptr_q] <= rd_data_i;
      end
    end
  end

endmodule

// File: rtl/pe_group_scheduler.sv
// Job sequencer for one PE_Group: three buffer readers feed W/I/O psum inputs, and
// the accumulated O results are written back to the result buffer in order.
module pe_group_scheduler
  import pe_sched_pkg::*;
#(
  parameter int DataWidth    = DATA_WIDTH,
  parameter int AddrWidth    = ADDR_WIDTH,
  parameter int TileCntWidth = TILE_CNT_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    aclr_ni,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [TileCntWidth-1:0] cfg_num_tiles_i,
  input  logic [AddrWidth-1:0]    cfg_w_base_i,
  input  logic [AddrWidth-1:0]    cfg_i_base_i,
  input  logic [AddrWidth-1:0]    cfg_o_base_i,
  input  logic [AddrWidth-1:0]    cfg_r_base_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    w_rd_en_o,
  output logic [AddrWidth-1:0]    w_rd_addr_o,
  input  logic [DataWidth-1:0]    w_rd_data_i,
  output logic                    i_rd_en_o,
  output logic [AddrWidth-1:0]    i_rd_addr_o,
  input  logic [DataWidth-1:0]    i_rd_data_i,
  output logic                    o_rd_en_o,
  output logic [AddrWidth-1:0]    o_rd_addr_o,
  input  logic [DataWidth-1:0]    o_rd_data_i,
  output logic                    r_wr_en_o,
  output logic [AddrWidth-1:0]    r_wr_addr_o,
  output logic [DataWidth-1:0]    r_wr_data_o,
  output logic                    pe_W_DataInValid_o,
  input  logic                    pe_W_DataInRdy_i,
  output logic [DataWidth-1:0]    pe_W_DataIn_o,
  output logic                    pe_I_DataInValid_o,
  input  logic                    pe_I_DataInRdy_i,
  output logic [DataWidth-1:0]    pe_I_DataIn_o,
  output logic                    pe_O_DataInValid_o,
  input  logic                    pe_O_DataInRdy_i,
  output logic [DataWidth-1:0]    pe_O_DataIn_o,
  input  logic                    pe_O_DataOutValid_i,
  output logic                    pe_O_DataOutRdy_o,
  input  logic [DataWidth-1:0]    pe_O_DataOut_i
);

  localparam int TotWidth = TileCntWidth + 4;

  sched_state_e         state_q, state_d;
  logic [TotWidth-1:0]  wr_count_q, wr_count_d;
  logic [TotWidth-1:0]  wr_total_q, wr_total_d;
  logic [AddrWidth-1:0] r_base_q, r_base_d;

  logic load;
  logic running;
  logic wr_fire;

  logic [NUM_STREAMS-1:0] rd_en;
  logic [NUM_STREAMS-1:0] pe_valid;
  logic [NUM_STREAMS-1:0] pe_rdy;
  logic [AddrWidth-1:0]   base    [NUM_STREAMS];
  logic [AddrWidth-1:0]   rd_addr [NUM_STREAMS];
  logic [DataWidth-1:0]   rd_data [NUM_STREAMS];
  logic [DataWidth-1:0]   pe_data [NUM_STREAMS];

  assign running = (state_q == ST_RUN);
  assign load    = start_i && (state_q == ST_IDLE) && !abort_i;
  assign wr_fire = running && pe_O_DataOutValid_i;

  assign base[0]    = cfg_w_base_i;
  assign base[1]    = cfg_i_base_i;
  assign base[2]    = cfg_o_base_i;
  assign rd_data[0] = w_rd_data_i;
  assign rd_data[1] = i_rd_data_i;
  assign rd_data[2] = o_rd_data_i;
  assign pe_rdy     = {pe_O_DataInRdy_i, pe_I_DataInRdy_i, pe_W_DataInRdy_i};

  for (genvar gi = 0; gi < NUM_STREAMS; gi++) begin : g_reader
    pe_stream_reader #(
      .DataWidth   (DataWidth),
      .AddrWidth   (AddrWidth),
      .TileCntWidth(TileCntWidth),
      .Words       (stream_words(gi))
    ) u_reader (
      .clk_i      (clk_i),
      .aclr_ni    (aclr_ni),
      .load_i     (load),
      .num_tiles_i(cfg_num_tiles_i),
      .base_i     (base[gi]),
      .en_i       (running),
      .flush_i    (abort_i),
      .rd_en_o    (rd_en[gi]),
      .rd_addr_o  (rd_addr[gi]),
      .rd_data_i  (rd_data[gi]),
      .valid_o    (pe_valid[gi]),
      .rdy_i      (pe_rdy[gi]),
      .data_o     (pe_data[gi])
    );
  end

  assign w_rd_en_o          = rd_en[0];
  assign w_rd_addr_o        = rd_addr[0];
  assign i_rd_en_o          = rd_en[1];
  assign i_rd_addr_o        = rd_addr[1];
  assign o_rd_en_o          = rd_en[2];
  assign o_rd_addr_o        = rd_addr[2];
  assign pe_W_DataInValid_o = pe_valid[0];
  assign pe_W_DataIn_o      = pe_data[0];
  assign pe_I_DataInValid_o = pe_valid[1];
  assign pe_I_DataIn_o      = pe_data[1];
  assign pe_O_DataInValid_o = pe_valid[2];
  assign pe_O_DataIn_o      = pe_data[2];

  assign busy_o            = (state_q != ST_IDLE);
  assign done_o            = (state_q == ST_DONE) && !abort_i;
  assign pe_O_DataOutRdy_o = running;
  assign r_wr_en_o         = wr_fire;
  assign r_wr_addr_o       = r_base_q + AddrWidth'(wr_count_q);
  assign r_wr_data_o       = wr_fire ? pe_O_DataOut_i : '0;

  always_comb begin
    state_d    = state_q;
    wr_count_d = wr_count_q;
    wr_total_d = wr_total_q;
    r_base_d   = r_base_q;
    if (wr_fire) begin
      wr_count_d = wr_count_q + TotWidth'(1);
    end
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          wr_count_d = '0;
          wr_total_d = TotWidth'(cfg_num_tiles_i) * TotWidth'(O_WORDS);
          r_base_d   = cfg_r_base_i;
          state_d    = (cfg_num_tiles_i == '0) ? ST_DONE : ST_RUN;
        end
      end
      // Compare against the post-write count so rdy drops right after the last result.
      ST_RUN: begin
        if (wr_count_d == wr_total_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_i) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge aclr_ni) begin
    if (!aclr_ni) begin
      state_q    <= ST_IDLE;
      wr_count_q <= '0;
      wr_total_q <= '0;
      r_base_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
      wr_total_q <= wr_total_d;
      r_base_q   <= r_base_d;
    end
  end

endmodule

// File: tb/tb_pe_group_scheduler.sv
// Scoreboard bench: jobs push expected reads/transfers/writes; a negedge monitor pops and checks.
module tb_pe_group_scheduler;

  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          aclr_n, start, abort;
  logic [7:0]    cfg_tiles;
  logic [AW-1:0] cfg_base [4];
  logic          busy, done;
  logic [2:0]    rd_en;
  logic [AW-1:0] rd_addr [3];
  logic [DW-1:0] rd_data [3];
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [DW-1:0] r_wr_data;
  logic [2:0]    in_valid, in_rdy;
  logic [DW-1:0] in_data [3];
  logic          o_res_valid, o_res_rdy;
  logic [DW-1:0] o_res_data;

  pe_group_scheduler dut (
    .clk_i(clk), .aclr_ni(aclr_n), .start_i(start), .abort_i(abort),
    .cfg_num_tiles_i(cfg_tiles),
    .cfg_w_base_i(cfg_base[0]), .cfg_i_base_i(cfg_base[1]),
    .cfg_o_base_i(cfg_base[2]), .cfg_r_base_i(cfg_base[3]),
    .busy_o(busy), .done_o(done),
    .w_rd_en_o(rd_en[0]), .w_rd_addr_o(rd_addr[0]), .w_rd_data_i(rd_data[0]),
    .i_rd_en_o(rd_en[1]), .i_rd_addr_o(rd_addr[1]), .i_rd_data_i(rd_data[1]),
    .o_rd_en_o(rd_en[2]), .o_rd_addr_o(rd_addr[2]), .o_rd_data_i(rd_data[2]),
    .r_wr_en_o(r_wr_en), .r_wr_addr_o(r_wr_addr), .r_wr_data_o(r_wr_data),
    .pe_W_DataInValid_o(in_valid[0]), .pe_W_DataInRdy_i(in_rdy[0]), .pe_W_DataIn_o(in_data[0]),
    .pe_I_DataInValid_o(in_valid[1]), .pe_I_DataInRdy_i(in_rdy[1]), .pe_I_DataIn_o(in_data[1]),
    .pe_O_DataInValid_o(in_valid[2]), .pe_O_DataInRdy_i(in_rdy[2]), .pe_O_DataIn_o(in_data[2]),
    .pe_O_DataOutValid_i(o_res_valid), .pe_O_DataOutRdy_o(o_res_rdy), .pe_O_DataOut_i(o_res_data)
  );

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [DW-1:0] mem [3][1024];
  logic [AW-1:0] qa0[$], qa1[$], qa2[$];
  logic [DW-1:0] qd0[$], qd1[$], qd2[$];
  logic [AW+DW-1:0] qwr[$];
  logic [DW-1:0] res_data[$];

  int      xfer [3];
  bit      pend_en [3];
  logic [AW-1:0] pend_addr [3];
  bit      o_fire;
  int      done_seen = 0, done_exp = 0, busy_cycles = 0;
  int      mode [3];
  int      res_total = 0, res_idx = 0;
  bit      job_active = 0, res_slow = 0;

  function automatic int words(input int s);
    return (s == 1) ? 7 : 4;
  endfunction

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void push_exp(input int s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    case (s)
      0: begin qa0.push_back(a); qd0.push_back(d); end
      1: begin qa1.push_back(a); qd1.push_back(d); end
      default: begin qa2.push_back(a); qd2.push_back(d); end
    endcase
  endfunction

  function automatic int qa_size(input int s);
    case (s) 0: return qa0.size(); 1: return qa1.size(); default: return qa2.size(); endcase
  endfunction

  function automatic int qd_size(input int s);
    case (s) 0: return qd0.size(); 1: return qd1.size(); default: return qd2.size(); endcase
  endfunction

  function automatic logic [AW-1:0] qa_pop(input int s);
    case (s) 0: return qa0.pop_front(); 1: return qa1.pop_front(); default: return qa2.pop_front(); endcase
  endfunction

  function automatic logic [DW-1:0] qd_pop(input int s);
    case (s) 0: return qd0.pop_front(); 1: return qd1.pop_front(); default: return qd2.pop_front(); endcase
  endfunction

  function automatic void clear_sb();
    qa0.delete(); qa1.delete(); qa2.delete();
    qd0.delete(); qd1.delete(); qd2.delete();
    qwr.delete(); res_data.delete();
  endfunction

  // Monitor: samples mid-cycle, pops expectations on every observed event.
  always @(negedge clk) begin
    for (int s = 0; s < 3; s++) begin
      pend_en[s]   = rd_en[s];
      pend_addr[s] = rd_addr[s];
      if (rd_en[s]) begin
        if (qa_size(s) == 0) check($sformatf("rd_en_extra[%0d]", s), rd_en[s], 0);
        else check($sformatf("rd_addr[%0d]", s), rd_addr[s], qa_pop(s));
      end
      if (in_valid[s] && in_rdy[s]) begin
        xfer[s]++;
        if (qd_size(s) == 0) check($sformatf("in_xfer_extra[%0d]", s), in_valid[s], 0);
        else check($sformatf("in_data[%0d]", s), in_data[s], qd_pop(s));
      end
    end
    o_fire = o_res_valid && o_res_rdy;
    if (r_wr_en) begin
      if (qwr.size() == 0) check("wr_extra", r_wr_en, 0);
      else check("wr_addr_data", {r_wr_addr, r_wr_data}, qwr.pop_front());
    end
    if (busy) busy_cycles++;
    if (done) begin
      if (done_seen >= done_exp) check("done_unexpected", done, 0);
      else check("done_leftover", qa0.size() + qa1.size() + qa2.size() + qd0.size()
                 + qd1.size() + qd2.size() + qwr.size(), 0);
      done_seen++;
    end
  end

  // Buffer RAMs (1-cycle read latency), PE ready patterns and PE result source.
  initial begin
    in_rdy      = 3'b000;
    o_res_valid = 1'b0;
    o_res_data  = '0;
    for (int s = 0; s < 3; s++) rd_data[s] = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
        rd_data[s] = pend_en[s] ? mem[s][pend_addr[s]] : $urandom;
        case (mode[s])
          0:       in_rdy[s] = 1'b1;
          1:       in_rdy[s] = ~in_rdy[s];
          default: in_rdy[s] = ($urandom % 3) != 0;
        endcase
      end
      if (o_fire) begin
        res_idx++;
        o_res_valid = 1'b0;
      end
      if (!job_active) begin
        o_res_valid = 1'b0;
      end else if (!o_res_valid && res_idx < res_total
                   && xfer[0] >= (res_idx / 4 + 1) * 4
                   && xfer[1] >= (res_idx / 4 + 1) * 7
                   && xfer[2] >= (res_idx / 4 + 1) * 4
                   && (!res_slow || ($urandom % 2) == 0)) begin
        o_res_valid = 1'b1;
        o_res_data  = res_data[res_idx];
      end
    end
  end

  task automatic start_job(input int tiles, input int wb, input int ib, input int ob, input int rb);
    int b [3];
    logic [DW-1:0] d;
    b[0] = wb; b[1] = ib; b[2] = ob;
    @(posedge clk);
    #2;
    clear_sb();
    cfg_tiles   = 8'(tiles);
    cfg_base[0] = AW'(wb);
    cfg_base[1] = AW'(ib);
    cfg_base[2] = AW'(ob);
    cfg_base[3] = AW'(rb);
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < tiles * words(s); k++)
        push_exp(s, AW'(b[s] + k), mem[s][(b[s] + k) % 1024]);
    for (int j = 0; j < tiles * 4; j++) begin
      d = $urandom;
      res_data.push_back(d);
      qwr.push_back({AW'(rb + j), d});
    end
    res_total = tiles * 4;
    res_idx   = 0;
    for (int s = 0; s < 3; s++) xfer[s] = 0;
    busy_cycles = 0;
    job_active  = 1'b1;
    done_exp++;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done_seen < done_exp && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, done_seen, done_exp);
    @(posedge clk);
    #2;
    check({name, "_busy_after"}, busy, 0);
    check({name, "_done_pulse"}, done, 0);
    job_active = 1'b0;
  endtask

  function automatic void set_modes(input int m0, input int m1, input int m2);
    mode[0] = m0; mode[1] = m1; mode[2] = m2;
  endfunction

  initial begin
    int n;
    aclr_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_tiles = '0;
    for (int r = 0; r < 4; r++) cfg_base[r] = '0;
    set_modes(0, 0, 0);
    for (int s = 0; s < 3; s++)
      for (int a = 0; a < 1024; a++) mem[s][a] = $urandom;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", |{busy, done, rd_en, rd_addr[0], rd_addr[1], rd_addr[2], r_wr_en,
          r_wr_addr, r_wr_data, in_valid, in_data[0], in_data[1], in_data[2], o_res_rdy}, 0);
    @(posedge clk);
    #2;
    aclr_n = 1'b1;

    // reset in the middle of a running job
    set_modes(2, 2, 2); res_slow = 1'b1;
    start_job(2, 100, 200, 300, 400);
    repeat (8) @(posedge clk);
    #2;
    check("midrun_busy_before_reset", busy, 1);
    aclr_n = 1'b0;
    @(negedge clk);
    check("midrun_reset_outputs", |{busy, done, rd_en, rd_addr[0], rd_addr[1], rd_addr[2], r_wr_en,
          r_wr_addr, r_wr_data, in_valid, in_data[0], in_data[1], in_data[2], o_res_rdy}, 0);
    @(posedge clk);
    #2;
    aclr_n = 1'b1; job_active = 1'b0; clear_sb(); done_exp = done_seen;
    start_job(1, 100, 200, 300, 400);
    wait_done("after_reset");

    // single tile, everything ready, results returned at once
    set_modes(0, 0, 0); res_slow = 1'b0;
    start_job(1, 0, 16, 32, 48);
    wait_done("one_tile");

    // W ready toggling every cycle
    set_modes(1, 0, 0);
    start_job(3, 0, 16, 32, 48);
    wait_done("w_toggle");

    // empty job
    set_modes(0, 0, 0);
    start_job(0, 5, 6, 7, 8);
    wait_done("zero_tiles");
    check("zero_tiles_busy_cycles", busy_cycles, 1);

    // abort after five I transfers
    set_modes(2, 2, 2); res_slow = 1'b1;
    start_job(2, 500, 600, 700, 800);
    n = 0;
    while (xfer[1] < 5 && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("abort_reached_5_i", xfer[1] >= 5, 1);
    abort = 1'b1;
    @(posedge clk);
    #2;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    job_active = 1'b0; clear_sb(); done_exp = done_seen;
    repeat (10) @(negedge clk);
    check("abort_no_done", done_seen, done_exp);
    start_job(1, 500, 600, 700, 800);
    wait_done("after_abort");

    // start during RUN ignored, result address wraps
    set_modes(0, 0, 0); res_slow = 1'b1;
    start_job(1, 40, 50, 60, 1023);
    @(posedge clk);
    #2;
    cfg_tiles = 8'd5; cfg_base[0] = 10'd900; cfg_base[1] = 10'd901;
    cfg_base[2] = 10'd902; cfg_base[3] = 10'd3; start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done("restart_ignored");
    repeat (10) @(negedge clk);
    check("restart_single_done", done_seen, done_exp);

    // random jobs
    for (int t = 0; t < 4; t++) begin
      set_modes($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
      res_slow = 1'($urandom % 2);
      start_job($urandom_range(1, 4), $urandom_range(0, 1023), $urandom_range(0, 1023),
                $urandom_range(0, 1023), $urandom_range(0, 1023));
      wait_done($sformatf("random%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
